// File: rtl/demux_4_to_1_reg.sv
// Registered 1-to-4 demultiplexer: routes i to lane {s1,s0} with a one-cycle
// latency, producing a one-hot per-lane valid strobe and a registered select.
module demux_4_to_1_reg #(
  parameter int unsigned WIDTH     = 1,
  parameter bit          IDLE_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y0,
  output logic [3:0]       vld,
  output logic [1:0]       sel_q
);

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  logic [NUM_LANES-1:0][WIDTH-1:0] y_q;
  logic [NUM_LANES-1:0][WIDTH-1:0] y_d;
  logic [NUM_LANES-1:0]            vld_q;
  logic [NUM_LANES-1:0]            vld_d;
  logic [SEL_W-1:0]                sel_d;
  logic [SEL_W-1:0]                sel_c;

  assign sel_c = {s1, s0};

  // Next-state: selected lane captures i; unselected lanes clear or hold.
  always_comb begin
    y_d   = y_q;
    vld_d = '0;
    sel_d = sel_q;
    if (en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (sel_c == SEL_W'(k)) begin
          y_d[k] = i;
        end else if (IDLE_ZERO) begin
          y_d[k] = '0;
        end
      end
      vld_d[sel_c] = 1'b1;
      sel_d        = sel_c;
    end
  end

  // Synchronous reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= '0;
      sel_q <= '0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      sel_q <= sel_d;
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign vld = vld_q;

endmodule

// File: tb/tb_demux_4_to_1_reg.sv
// Scoreboard bench for demux_4_to_1_reg: three instances (1-bit clear-idle,
// 8-bit hold-idle, 8-bit clear-idle) share stimulus; expectations are queued.
module tb_demux_4_to_1_reg;

  typedef struct packed {
    logic [3:0][7:0] y;
    logic [3:0]      vld;
    logic [1:0]      sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       s1;
  logic       s0;
  logic [7:0] i_bus;

  logic [0:0] w_y3, w_y2, w_y1, w_y0;
  logic [3:0] w_vld;
  logic [1:0] w_sel;
  logic [7:0] h_y3, h_y2, h_y1, h_y0;
  logic [3:0] h_vld;
  logic [1:0] h_sel;
  logic [7:0] z_y3, z_y2, z_y1, z_y0;
  logic [3:0] z_vld;
  logic [1:0] z_sel;

  exp_t m0, m1, m2;
  exp_t e0, e1, e2;
  exp_t q0[$], q1[$], q2[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  demux_4_to_1_reg #(.WIDTH(1), .IDLE_ZERO(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0), .i(i_bus[0:0]),
    .y3(w_y3), .y2(w_y2), .y1(w_y1), .y0(w_y0), .vld(w_vld), .sel_q(w_sel)
  );

  demux_4_to_1_reg #(.WIDTH(8), .IDLE_ZERO(1'b0)) u_hold (
    .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0), .i(i_bus),
    .y3(h_y3), .y2(h_y2), .y1(h_y1), .y0(h_y0), .vld(h_vld), .sel_q(h_sel)
  );

  demux_4_to_1_reg #(.WIDTH(8), .IDLE_ZERO(1'b1)) u_zero (
    .clk(clk), .rst(rst), .en(en), .s1(s1), .s0(s0), .i(i_bus),
    .y3(z_y3), .y2(z_y2), .y1(z_y1), .y0(z_y0), .vld(z_vld), .sel_q(z_sel)
  );

  // Behavioural model of one clock edge for a given idle policy.
  function automatic exp_t next_exp(input exp_t m, input bit iz, input logic [7:0] d,
                                    input logic r, input logic e, input logic [1:0] s);
    exp_t n = m;
    if (r) return '0;
    n.vld = 4'b0000;
    if (e) begin
      for (int k = 0; k < 4; k++) begin
        if (k == int'(s)) n.y[k] = d;
        else if (iz) n.y[k] = 8'h00;
      end
      n.vld = 4'b0001 << s;
      n.sel = s;
    end
    return n;
  endfunction

  // Drive one cycle of stimulus, queue expectations, then pop them after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; {s1, s0} = s; i_bus = d;
    m0 = next_exp(m0, 1'b1, {7'b0, d[0]}, r, e, s);
    m1 = next_exp(m1, 1'b0, d, r, e, s);
    m2 = next_exp(m2, 1'b1, d, r, e, s);
    q0.push_back(m0);
    q1.push_back(m1);
    q2.push_back(m2);
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    e2 = q2.pop_front();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b1, 2'b11, 8'hFF);
      checks++;
      if ({w_y3, w_y2, w_y1, w_y0, w_vld, w_sel} !== 10'h000)
        $display("FAIL reset_w1 cyc%0d got=%h exp=000", c, {w_y3, w_y2, w_y1, w_y0, w_vld, w_sel});
      else passed++;
      checks++;
      if ({h_y3, h_y2, h_y1, h_y0, h_vld, h_sel} !== e1)
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", c, {h_y3, h_y2, h_y1, h_y0, h_vld, h_sel}, e1);
      else passed++;
      checks++;
      if ({z_y3, z_y2, z_y1, z_y0, z_vld, z_sel} !== e2)
        $display("FAIL reset_zero cyc%0d got=%h exp=%h", c, {z_y3, z_y2, z_y1, z_y0, z_vld, z_sel}, e2);
      else passed++;
    end
  endtask

  task automatic test_truth_table();
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv = 3'(v);
      step(1'b0, 1'b1, vv[2:1], {7'b0, vv[0]});
      checks++;
      if ({w_y3, w_y2, w_y1, w_y0, w_vld, w_sel} !==
          {e0.y[3][0], e0.y[2][0], e0.y[1][0], e0.y[0][0], e0.vld, e0.sel})
        $display("FAIL truth_table v=%0d got=%b exp=%b", v,
                 {w_y3, w_y2, w_y1, w_y0, w_vld, w_sel},
                 {e0.y[3][0], e0.y[2][0], e0.y[1][0], e0.y[0][0], e0.vld, e0.sel});
      else passed++;
    end
  endtask

  task automatic test_hold();
    logic [1:0] sels [3] = '{2'b00, 2'b10, 2'b00};
    logic [7:0] data [3] = '{8'hA5, 8'h3C, 8'hFF};
    step(1'b1, 1'b0, 2'b00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, sels[c], data[c]);
      checks++;
      if ({h_y3, h_y2, h_y1, h_y0, h_vld, h_sel} !== e1)
        $display("FAIL hold cyc%0d got=%h exp=%h", c, {h_y3, h_y2, h_y1, h_y0, h_vld, h_sel}, e1);
      else passed++;
    end
    checks++;
    if ({h_y3, h_y2, h_y1, h_y0} !== 32'h003C_00FF)
      $display("FAIL hold_final got=%h exp=003c00ff", {h_y3, h_y2, h_y1, h_y0});
    else passed++;
  endtask

  task automatic test_enable();
    step(1'b0, 1'b1, 2'b01, 8'h55);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 2'b11, 8'hAA);
      checks++;
      if ({h_y3, h_y2, h_y1, h_y0, h_vld, h_sel} !== e1)
        $display("FAIL enable_hold cyc%0d got=%h exp=%h", c, {h_y3, h_y2, h_y1, h_y0, h_vld, h_sel}, e1);
      else passed++;
      checks++;
      if ({z_y3, z_y2, z_y1, z_y0, z_vld, z_sel} !== e2)
        $display("FAIL enable_zero cyc%0d got=%h exp=%h", c, {z_y3, z_y2, z_y1, z_y0, z_vld, z_sel}, e2);
      else passed++;
    end
  endtask

  task automatic test_reset_priority();
    step(1'b1, 1'b1, 2'b10, 8'h7E);
    checks++;
    if ({z_y3, z_y2, z_y1, z_y0, z_vld, z_sel} !== e2)
      $display("FAIL rst_prio got=%h exp=%h", {z_y3, z_y2, z_y1, z_y0, z_vld, z_sel}, e2);
    else passed++;
    step(1'b0, 1'b1, 2'b10, 8'h7E);
    checks++;
    if ({z_y3, z_y2, z_y1, z_y0, z_vld, z_sel} !== e2)
      $display("FAIL rst_release got=%h exp=%h", {z_y3, z_y2, z_y1, z_y0, z_vld, z_sel}, e2);
    else passed++;
    checks++;
    if ({z_y2, z_vld} !== 12'h7E4)
      $display("FAIL rst_release_lane2 got=%h exp=7e4", {z_y2, z_vld});
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 2'(k), 8'(k + 1));
      checks++;
      if ({z_y3, z_y2, z_y1, z_y0, z_vld, z_sel} !== e2)
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, {z_y3, z_y2, z_y1, z_y0, z_vld, z_sel}, e2);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s1 = 1'b0; s0 = 1'b0; i_bus = 8'h00;
    m0 = '0; m1 = '0; m2 = '0;
    test_reset();
    test_truth_table();
    test_hold();
    test_enable();
    test_reset_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/demux_4_to_1_reg.md
Name: demux_4_to_1_reg

Overview:
Registered 1-to-4 demultiplexer. Routes a single input bus to one of four output buses chosen by a 2-bit select (s1 = MSB, s0 = LSB). Outputs and per-lane valid strobes are registered on the rising edge of clk. It is used as a routing stage wherever one producer feeds four consumer lanes.

Parameters:
WIDTH, 1, bit width of data input i and of each output y0..y3 (legal range 1..64)
IDLE_ZERO, 1, 1 = unselected outputs are cleared to 0 every enabled cycle; 0 = unselected outputs hold their previous value

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous reset, active-high
en  input  1  capture enable; when 0, all outputs hold
s1  input  1  select MSB
s0  input  1  select LSB
i  input  WIDTH  data input
y3  output  WIDTH  lane 3 data; selected when {s1,s0}=11
y2  output  WIDTH  lane 2 data; selected when {s1,s0}=10
y1  output  WIDTH  lane 1 data; selected when {s1,s0}=01
y0  output  WIDTH  lane 0 data; selected when {s1,s0}=00
vld  output  4  one-hot lane strobe; bit k=1 for one cycle after lane k captured data
sel_q  output  2  registered copy of {s1,s0} from the last enabled cycle

Behaviour:
- Reset: synchronous and active-high. On a clk edge with rst=1, y0..y3 = 0, vld = 4'b0000 and sel_q = 2'b00. Reset has priority over en.
- Enabled cycle (rst=0, en=1), with k = {s1,s0}:
  - y_k <= i.
  - IDLE_ZERO=1: the other three outputs <= 0.
  - IDLE_ZERO=0: the other three outputs hold.
  - vld <= one-hot(k): 00->0001, 01->0010, 10->0100, 11->1000.
  - sel_q <= {s1,s0}.
- Disabled cycle (rst=0, en=0): y0..y3 and sel_q hold; vld <= 0000.
- Latency: exactly one clock edge from input to output. There is no combinational path from inputs to outputs.
- Data value independence: an input of i=0 still selects a lane and asserts that lane's vld bit. A zero data word is a valid transfer.
- Select changing every cycle: each cycle routes independently. No state is carried between cycles other than the hold behaviour defined above.
- X or Z on s1/s0 is not supported. The bench shall drive only 0/1.
- Reset mid-stream: the next edge with rst=1 clears everything. The first enabled edge after rst deasserts routes normally.
- Bit order: i[n] maps to y_k[n]; no reordering, sign extension or truncation.

Test Plan:
1. Reset: rst=1 for 2 cycles with i=all 1s, {s1,s0}=11, en=1 -> y0..y3=0, vld=0000, sel_q=00 after each edge.
2. Exhaustive truth table (WIDTH=1, IDLE_ZERO=1, en=1): step {s1,s0,i} through 000..111, one combination per cycle. One cycle later:
   - sel 00, i=1 -> y0=1, others 0.
   - sel 01, i=1 -> y1=1, others 0.
   - sel 10, i=1 -> y2=1, others 0.
   - sel 11, i=1 -> y3=1, others 0.
   - every i=0 case -> all outputs 0, vld still one-hot for that select.
3. Hold mode (WIDTH=8, IDLE_ZERO=0):
   - route 0xA5 to lane 0, then 0x3C to lane 2 -> y0=0xA5, y2=0x3C, y1=y3=0x00.
   - then route 0xFF to lane 0 -> y0=0xFF, y2 still 0x3C.
4. Enable gating: load y1=0x55 with en=1, then en=0 for 3 cycles while sel=11 and i=0xAA -> y1=0x55, y3 unchanged, vld=0000 on each disabled cycle.
5. Reset priority: rst=1 and en=1 on the same edge with sel=10, i=0x7E -> all outputs 0, vld=0000. After rst=0, the next enabled edge -> y2=0x7E, vld=0100.
6. Back-to-back select rotation 00,01,10,11 with i=1,2,3,4 (WIDTH=8, IDLE_ZERO=1) -> on consecutive cycles vld=0001,0010,0100,1000 with the matching lane value 1,2,3,4, and sel_q tracking 00,01,10,11.
